// File: rtl/snake_game_engine.sv
// snake_game_engine: per-tick game logic for the snake game.
//   - 16-bit LFSR random source (seed 16'hACE1, never all-zero)
//   - fruit placer/consumer: grows/shrinks the snake or adds a life on a hit,
//     then re-rolls the fruit until it lands on a free cell
//   - collision checker: boundary and self hits cost a life and respawn the head
// All outputs are registered; each output reflects the inputs one cycle earlier.
// Optional build macro: SNAKE_WRAP_EN -- boundary crossings wrap the head to the
// opposite edge instead of counting as a collision (self hits still collide).
module snake_game_engine #(
  parameter int COORD_WIDTH    = 10,
  parameter int MAX_LENGTH     = 63,
  parameter int LENGTH_WIDTH   = 6,
  parameter int DISPLAY_WIDTH  = 64,
  parameter int DISPLAY_HEIGHT = 48,
  parameter int INIT_LENGTH    = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [COORD_WIDTH-1:0]                snakehead_x,
  input  logic [COORD_WIDTH-1:0]                snakehead_y,
  input  logic [(MAX_LENGTH+1)*COORD_WIDTH-1:0] snakebody_x,
  input  logic [(MAX_LENGTH+1)*COORD_WIDTH-1:0] snakebody_y,
  input  logic [LENGTH_WIDTH-1:0]               snake_length_in,
  input  logic [2:0]                            lives_in,
  output logic [15:0]                           random_number,
  output logic [COORD_WIDTH-1:0]                fruit_x,
  output logic [COORD_WIDTH-1:0]                fruit_y,
  output logic [1:0]                            fruit_type,
  output logic                                  food_eaten,
  output logic [(MAX_LENGTH+1)*COORD_WIDTH-1:0] new_snakebody_x,
  output logic [(MAX_LENGTH+1)*COORD_WIDTH-1:0] new_snakebody_y,
  output logic [LENGTH_WIDTH-1:0]               fruit_length_out,
  output logic [2:0]                            fruit_lives_out,
  output logic                                  collision,
  output logic                                  game_over,
  output logic [2:0]                            collision_lives_out,
  output logic [LENGTH_WIDTH-1:0]               collision_length_out,
  output logic [COORD_WIDTH-1:0]                new_head_x,
  output logic [COORD_WIDTH-1:0]                new_head_y
);

  localparam int ENTRIES = MAX_LENGTH + 1;
  localparam int BODY_W  = ENTRIES * COORD_WIDTH;
  localparam int LEN_EXT = LENGTH_WIDTH + 1;

  typedef logic [COORD_WIDTH-1:0]  coord_t;
  typedef logic [LENGTH_WIDTH-1:0] len_t;
  typedef logic [LEN_EXT-1:0]      len_ext_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam coord_t      FRUIT_X0  = coord_t'(16);
  localparam coord_t      FRUIT_Y0  = coord_t'(12);
  localparam coord_t      HOME_X    = coord_t'(DISPLAY_WIDTH / 2);
  localparam coord_t      HOME_Y    = coord_t'(DISPLAY_HEIGHT / 2);
  localparam coord_t      LIMIT_X   = coord_t'(DISPLAY_WIDTH);
  localparam coord_t      LIMIT_Y   = coord_t'(DISPLAY_HEIGHT);
  localparam len_t        INIT_LEN  = len_t'(INIT_LENGTH);
  localparam len_ext_t    LEN_CAP   = len_ext_t'(MAX_LENGTH);
  localparam logic [5:0]  FOLD_Y    = 6'(DISPLAY_HEIGHT);

  // Fruit kinds
  localparam logic [1:0] FRUIT_NORMAL = 2'd0;
  localparam logic [1:0] FRUIT_BONUS  = 2'd1;
  localparam logic [1:0] FRUIT_SHRINK = 2'd2;

  logic [15:0]       rand_q, rand_d;
  coord_t            fruit_x_q, fruit_x_d, fruit_y_q, fruit_y_d;
  logic [1:0]        fruit_type_q, fruit_type_d;
  logic              relocate_q, relocate_d;
  logic              food_eaten_q, food_eaten_d;
  logic [BODY_W-1:0] body_x_q, body_x_d, body_y_q, body_y_d;
  len_t              fruit_len_q, fruit_len_d;
  logic [2:0]        fruit_lives_q, fruit_lives_d;
  logic              collision_q, collision_d;
  logic              game_over_q, game_over_d;
  logic [2:0]        coll_lives_q, coll_lives_d;
  len_t              coll_len_q, coll_len_d;
  coord_t            head_x_q, head_x_d, head_y_q, head_y_d;

  // LFSR: shift left, feedback taps 15/13/12/10; a non-zero seed keeps it non-zero
  assign rand_d = {rand_q[14:0], rand_q[15] ^ rand_q[13] ^ rand_q[12] ^ rand_q[10]};

  logic [5:0] cand_y_raw;
  coord_t     cand_x, cand_y;
  logic [1:0] cand_type;
  logic       cand_blocked;

  // Relocation candidate drawn from the LFSR, and whether it lands on the snake
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cand_x       = coord_t'(rand_q[5:0]);
    cand_y_raw   = rand_q[13:8];
    cand_y       = (cand_y_raw >= FOLD_Y) ? coord_t'(cand_y_raw - FOLD_Y) : coord_t'(cand_y_raw);
    cand_type    = rand_q[15:14];
    cand_blocked = (cand_x == snakehead_x) && (cand_y == snakehead_y);
    for (int i = 0; i < ENTRIES; i++) begin
      if ((len_t'(i) < snake_length_in) &&
          (snakebody_x[i*COORD_WIDTH +: COORD_WIDTH] == cand_x) &&
          (snakebody_y[i*COORD_WIDTH +: COORD_WIDTH] == cand_y))
        cand_blocked = 1'b1;
    end
  end

  logic       eat_hit;
  logic [1:0] grow_by;
  len_ext_t   grown;
  len_t       tail_idx;
  coord_t     tail_x, tail_y;

  // Fruit consumption: length/lives effect, body growth and fruit relocation
  always_comb begin
    eat_hit       = (snakehead_x == fruit_x_q) && (snakehead_y == fruit_y_q) && !relocate_q;
    food_eaten_d  = eat_hit;
    fruit_x_d     = fruit_x_q;
    fruit_y_d     = fruit_y_q;
    fruit_type_d  = fruit_type_q;
    relocate_d    = relocate_q;
    fruit_len_d   = snake_length_in;
    fruit_lives_d = lives_in;
    grow_by       = 2'd0;

    if (eat_hit) begin
      unique case (fruit_type_q)
        FRUIT_NORMAL: grow_by = 2'd1;
        FRUIT_BONUS:  grow_by = 2'd2;
        FRUIT_SHRINK: fruit_len_d = (snake_length_in > len_t'(1)) ? snake_length_in - len_t'(1)
                                                                   : len_t'(1);
        default:      fruit_lives_d = (lives_in == 3'd7) ? 3'd7 : lives_in + 3'd1;
      endcase
    end

    grown = {1'b0, snake_length_in} + len_ext_t'(grow_by);
    if (grow_by != 2'd0)
      fruit_len_d = (grown > LEN_CAP) ? len_t'(LEN_CAP) : len_t'(grown);

    // Body passes through; freshly grown slots replicate the old tail cell
    tail_idx = snake_length_in - len_t'(1);
    tail_x   = snakebody_x[tail_idx*COORD_WIDTH +: COORD_WIDTH];
    tail_y   = snakebody_y[tail_idx*COORD_WIDTH +: COORD_WIDTH];
    body_x_d = snakebody_x;
    body_y_d = snakebody_y;
    if (eat_hit) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if ((len_t'(i) >= snake_length_in) && (len_t'(i) < fruit_len_d)) begin
          body_x_d[i*COORD_WIDTH +: COORD_WIDTH] = tail_x;
          body_y_d[i*COORD_WIDTH +: COORD_WIDTH] = tail_y;
        end
      end
    end

    // Keep re-rolling every cycle until the candidate lands on a free cell
    if (eat_hit || relocate_q) begin
      if (cand_blocked) begin
        relocate_d = 1'b1;
      end else begin
        fruit_x_d    = cand_x;
        fruit_y_d    = cand_y;
        fruit_type_d = cand_type;
        relocate_d   = 1'b0;
      end
    end
  end

  logic   self_hit, coll_hit;
  coord_t pass_x, pass_y;

  // Collision check: self hit (entry 0 is the head copy, so skipped) and boundary
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < ENTRIES; i++) begin
      if ((len_t'(i) < snake_length_in) &&
          (snakebody_x[i*COORD_WIDTH +: COORD_WIDTH] == snakehead_x) &&
          (snakebody_y[i*COORD_WIDTH +: COORD_WIDTH] == snakehead_y))
        self_hit = 1'b1;
    end
`ifdef SNAKE_WRAP_EN
    // Exactly one past the edge wraps to 0; anything further is an underflow from 0
    coll_hit = self_hit;
    pass_x   = (snakehead_x == LIMIT_X) ? '0 :
               (snakehead_x >  LIMIT_X) ? LIMIT_X - coord_t'(1) : snakehead_x;
    pass_y   = (snakehead_y == LIMIT_Y) ? '0 :
               (snakehead_y >  LIMIT_Y) ? LIMIT_Y - coord_t'(1) : snakehead_y;
`else
    coll_hit = self_hit || (snakehead_x >= LIMIT_X) || (snakehead_y >= LIMIT_Y);
    pass_x   = snakehead_x;
    pass_y   = snakehead_y;
`endif
    collision_d = coll_hit;
    if (coll_hit) begin
      coll_lives_d = (lives_in == 3'd0) ? 3'd0 : lives_in - 3'd1;
      coll_len_d   = INIT_LEN;
      head_x_d     = HOME_X;
      head_y_d     = HOME_Y;
    end else begin
      coll_lives_d = lives_in;
      coll_len_d   = snake_length_in;
      head_x_d     = pass_x;
      head_y_d     = pass_y;
    end
    game_over_d = (coll_lives_d == 3'd0);
  end

  // State registers; reset restores the power-on game state immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rand_q        <= LFSR_SEED;
      fruit_x_q     <= FRUIT_X0;
      fruit_y_q     <= FRUIT_Y0;
      fruit_type_q  <= FRUIT_NORMAL;
      relocate_q    <= 1'b0;
      food_eaten_q  <= 1'b0;
      // NOTE: the body outputs are plain flops, not a RAM, so they can and must reset to zero.
      body_x_q      <= '0;
      body_y_q      <= '0;
      fruit_len_q   <= INIT_LEN;
      fruit_lives_q <= 3'd3;
      collision_q   <= 1'b0;
      game_over_q   <= 1'b0;
      coll_lives_q  <= 3'd3;
      coll_len_q    <= INIT_LEN;
      head_x_q      <= HOME_X;
      head_y_q      <= HOME_Y;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rand_q        <= rand_d;
      fruit_x_q     <= fruit_x_d;
      fruit_y_q     <= fruit_y_d;
      fruit_type_q  <= fruit_type_d;
      relocate_q    <= relocate_d;
      food_eaten_q  <= food_eaten_d;
      body_x_q      <= body_x_d;
      body_y_q      <= body_y_d;
      fruit_len_q   <= fruit_len_d;
      fruit_lives_q <= fruit_lives_d;
      collision_q   <= collision_d;
      game_over_q   <= game_over_d;
      coll_lives_q  <= coll_lives_d;
      coll_len_q    <= coll_len_d;
      head_x_q      <= head_x_d;
      head_y_q      <= head_y_d;
    end
  end

  assign random_number        = rand_q;
  assign fruit_x              = fruit_x_q;
  assign fruit_y              = fruit_y_q;
  assign fruit_type           = fruit_type_q;
  assign food_eaten           = food_eaten_q;
  assign new_snakebody_x      = body_x_q;
  assign new_snakebody_y      = body_y_q;
  assign fruit_length_out     = fruit_len_q;
  assign fruit_lives_out      = fruit_lives_q;
  assign collision            = collision_q;
  assign game_over            = game_over_q;
  assign collision_lives_out  = coll_lives_q;
  assign collision_length_out = coll_len_q;
  assign new_head_x           = head_x_q;
  assign new_head_y           = head_y_q;

endmodule

// File: tb/tb_snake_game_engine.sv
// Self-checking bench for snake_game_engine: directed scenarios plus random
// ticks, all compared against a behavioural game model held in integers.
module tb_snake_game_engine;
  localparam int CW = 10;
  localparam int N  = 64;
  localparam int DW = 64;
  localparam int DH = 48;

  logic            clk = 1'b0;
  logic            reset;
  logic [CW-1:0]   snakehead_x, snakehead_y;
  logic [N*CW-1:0] snakebody_x, snakebody_y;
  logic [5:0]      snake_length_in;
  logic [2:0]      lives_in;
  logic [15:0]     random_number;
  logic [CW-1:0]   fruit_x, fruit_y, new_head_x, new_head_y;
  logic [1:0]      fruit_type;
  logic            food_eaten, collision, game_over;
  logic [N*CW-1:0] new_snakebody_x, new_snakebody_y;
  logic [5:0]      fruit_length_out, collision_length_out;
  logic [2:0]      fruit_lives_out, collision_lives_out;

  always #5 clk = ~clk;

  snake_game_engine dut (
    .clk(clk), .reset(reset),
    .snakehead_x(snakehead_x), .snakehead_y(snakehead_y),
    .snakebody_x(snakebody_x), .snakebody_y(snakebody_y),
    .snake_length_in(snake_length_in), .lives_in(lives_in),
    .random_number(random_number), .fruit_x(fruit_x), .fruit_y(fruit_y),
    .fruit_type(fruit_type), .food_eaten(food_eaten),
    .new_snakebody_x(new_snakebody_x), .new_snakebody_y(new_snakebody_y),
    .fruit_length_out(fruit_length_out), .fruit_lives_out(fruit_lives_out),
    .collision(collision), .game_over(game_over),
    .collision_lives_out(collision_lives_out),
    .collision_length_out(collision_length_out),
    .new_head_x(new_head_x), .new_head_y(new_head_y)
  );

  // Stimulus as plain integers
  int bx[N], by[N];
  int hx, hy, len, lives;
  // Game model state
  int m_rand, m_fx, m_fy, m_ft, m_reloc;
  // Expected outputs for the coming edge
  int e_rand, e_fx, e_fy, e_ft, e_eaten, e_flen, e_flives;
  int e_coll, e_go, e_clives, e_clen, e_hx, e_hy;
  int e_bx[N], e_by[N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [N*CW-1:0] obs, input logic [N*CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int next_lfsr(input int r);
    int fb;
    fb = ((r >> 15) ^ (r >> 13) ^ (r >> 12) ^ (r >> 10)) & 1;
    return ((r << 1) & 16'hFFFF) | fb;
  endfunction

  function automatic void model_reset();
    m_rand = 16'hACE1; m_fx = 16; m_fy = 12; m_ft = 0; m_reloc = 0;
  endfunction

  task automatic drive();
    snakehead_x     = CW'(hx);
    snakehead_y     = CW'(hy);
    snake_length_in = 6'(len);
    lives_in        = 3'(lives);
    for (int i = 0; i < N; i++) begin
      snakebody_x[i*CW +: CW] = CW'(bx[i]);
      snakebody_y[i*CW +: CW] = CW'(by[i]);
    end
  endtask

  // Predict the outputs after the next edge from the rules of the game
  task automatic model_step();
    int hit, cx, cy, ct, occ, slf, coll, px, py;
    hit = (hx == m_fx && hy == m_fy && m_reloc == 0) ? 1 : 0;
    e_eaten = hit; e_flen = len; e_flives = lives;
    for (int i = 0; i < N; i++) begin e_bx[i] = bx[i]; e_by[i] = by[i]; end
    if (hit == 1) begin
      case (m_ft)
        0: e_flen = (len + 1 > 63) ? 63 : len + 1;
        1: e_flen = (len + 2 > 63) ? 63 : len + 2;
        2: e_flen = (len > 1) ? len - 1 : 1;
        default: e_flives = (lives < 7) ? lives + 1 : 7;
      endcase
      for (int i = len; i < e_flen; i++) begin e_bx[i] = bx[len-1]; e_by[i] = by[len-1]; end
    end
    if (hit == 1 || m_reloc == 1) begin
      cx = m_rand & 63;
      cy = (m_rand >> 8) & 63;
      if (cy >= 48) cy -= 48;
      ct = (m_rand >> 14) & 3;
      occ = (cx == hx && cy == hy) ? 1 : 0;
      for (int i = 0; i < len; i++) if (bx[i] == cx && by[i] == cy) occ = 1;
      if (occ == 1) m_reloc = 1;
      else begin m_fx = cx; m_fy = cy; m_ft = ct; m_reloc = 0; end
    end
    e_fx = m_fx; e_fy = m_fy; e_ft = m_ft;

    slf = 0;
    for (int i = 1; i < len; i++) if (bx[i] == hx && by[i] == hy) slf = 1;
`ifdef SNAKE_WRAP_EN
    coll = slf;
    px = (hx == DW) ? 0 : (hx > DW) ? DW - 1 : hx;
    py = (hy == DH) ? 0 : (hy > DH) ? DH - 1 : hy;
`else
    coll = (slf == 1 || hx >= DW || hy >= DH) ? 1 : 0;
    px = hx; py = hy;
`endif
    e_coll = coll;
    if (coll == 1) begin
      e_clives = (lives > 0) ? lives - 1 : 0;
      e_clen = 3; e_hx = DW / 2; e_hy = DH / 2;
    end else begin
      e_clives = lives; e_clen = len; e_hx = px; e_hy = py;
    end
    e_go = (e_clives == 0) ? 1 : 0;
    m_rand = next_lfsr(m_rand);
    e_rand = m_rand;
  endtask

  task automatic compare_all();
    logic [N*CW-1:0] vx, vy;
    for (int i = 0; i < N; i++) begin
      vx[i*CW +: CW] = CW'(e_bx[i]);
      vy[i*CW +: CW] = CW'(e_by[i]);
    end
    check("random_number", random_number, e_rand);
    check("fruit_x", fruit_x, e_fx);
    check("fruit_y", fruit_y, e_fy);
    check("fruit_type", fruit_type, e_ft);
    check("food_eaten", food_eaten, e_eaten);
    check("fruit_length_out", fruit_length_out, e_flen);
    check("fruit_lives_out", fruit_lives_out, e_flives);
    check("collision", collision, e_coll);
    check("game_over", game_over, e_go);
    check("collision_lives_out", collision_lives_out, e_clives);
    check("collision_length_out", collision_length_out, e_clen);
    check("new_head_x", new_head_x, e_hx);
    check("new_head_y", new_head_y, e_hy);
    check_vec("new_snakebody_x", new_snakebody_x, vx);
    check_vec("new_snakebody_y", new_snakebody_y, vy);
  endtask

  // One clock: apply inputs, predict, sample 1 time unit after the edge
  task automatic tick();
    drive();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rand"}, random_number, 16'hACE1);
    check({tag, "_fruit_x"}, fruit_x, 16);
    check({tag, "_fruit_y"}, fruit_y, 12);
    check({tag, "_fruit_type"}, fruit_type, 0);
    check({tag, "_food_eaten"}, food_eaten, 0);
    check_vec({tag, "_body_x"}, new_snakebody_x, '0);
    check_vec({tag, "_body_y"}, new_snakebody_y, '0);
    check({tag, "_fruit_len"}, fruit_length_out, 3);
    check({tag, "_coll_len"}, collision_length_out, 3);
    check({tag, "_fruit_lives"}, fruit_lives_out, 3);
    check({tag, "_coll_lives"}, collision_lives_out, 3);
    check({tag, "_head_x"}, new_head_x, 32);
    check({tag, "_head_y"}, new_head_y, 24);
    check({tag, "_collision"}, collision, 0);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  // Keep eating until the fruit on the board has the wanted type, then eat it
  // with the given length and lives
  task automatic eat_type(input int want, input int l, input int lv);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (m_reloc == 1) begin
        hx = 5; hy = 5; len = 3; lives = 3;
      end else begin
        hx = m_fx; hy = m_fy;
        if (m_ft == want) begin len = l; lives = lv; done = 1'b1; end
        else begin len = 3; lives = 3; end
      end
      bx[0] = hx; by[0] = hy;
      tick();
    end
    check("eat_type_budget", done, 1);
  endtask

  initial begin
    int mode, k;
    for (int i = 0; i < N; i++) begin bx[i] = i; by[i] = 40; end
    hx = 5; hy = 5; bx[0] = 5; by[0] = 5; len = 3; lives = 3;
    reset = 1'b0;
    drive();
    #12;
    // 1: reset values, then LFSR sequence after release
    check_reset("rst");
    reset = 1'b1;
    model_reset();
    check("lfsr_seed_held", random_number, 16'hACE1);
    tick();
    check("lfsr_second", random_number, 16'h59C3);

    // 2: eat a normal fruit at (16,12) with length 3
    hx = 16; hy = 12; bx[0] = 16; by[0] = 12;
    tick();
    check("eat_pulse", food_eaten, 1);
    check("eat_len4", fruit_length_out, 4);
    check("eat_tail_copy", new_snakebody_x[3*CW +: CW], bx[2]);
    hx = 5; hy = 5; bx[0] = 5; by[0] = 5;
    tick();
    check("eat_pulse_end", food_eaten, 0);

    // 3: lives saturate on a life fruit; shrink floors at 1
    eat_type(3, 3, 7);
    check("life_sat", fruit_lives_out, 7);
    eat_type(2, 1, 3);
    check("shrink_floor", fruit_length_out, 1);
    hx = 5; hy = 5; bx[0] = 5; by[0] = 5; len = 3; lives = 3;
    tick();

    // 4: boundary crossing at x = 64
    hx = 64; hy = 20; lives = 3;
    tick();
`ifdef SNAKE_WRAP_EN
    check("wrap_no_coll", collision, 0);
    check("wrap_head_x", new_head_x, 0);
    check("wrap_head_y", new_head_y, 20);
    check("wrap_lives", collision_lives_out, 3);
`else
    check("bnd_coll", collision, 1);
    check("bnd_lives", collision_lives_out, 2);
    check("bnd_len", collision_length_out, 3);
    check("bnd_head_x", new_head_x, 32);
    check("bnd_head_y", new_head_y, 24);
`endif
    hx = 10; hy = 10; bx[0] = 10; by[0] = 10;
    tick();
    check("coll_pulse_end", collision, 0);

    // 5: self hit on entry 1; head on entry 0 alone is not a hit
    bx[0] = 20; by[0] = 20; bx[1] = 30; by[1] = 20; bx[2] = 1; by[2] = 40;
    hx = 30; hy = 20; len = 3; lives = 3;
    tick();
    check("self_coll", collision, 1);
    check("self_lives", collision_lives_out, 2);
    hx = 20; hy = 20;
    tick();
    check("entry0_no_coll", collision, 0);
    check("entry0_lives", collision_lives_out, 3);

    // 6: last life lost -> game over; zero lives stay zero
    hx = 30; hy = 20; lives = 1;
    tick();
    check("last_life", collision_lives_out, 0);
    check("game_over_set", game_over, 1);
    lives = 0;
    tick();
    check("zero_floor", collision_lives_out, 0);
    check("game_over_hold", game_over, 1);

    // Random ticks against the model
    for (int n = 0; n < 400; n++) begin
      len   = $urandom_range(1, 63);
      lives = $urandom_range(0, 7);
      for (int i = 0; i < N; i++) begin
        bx[i] = $urandom_range(0, DW - 1);
        by[i] = $urandom_range(0, DH - 1);
      end
      mode = $urandom_range(0, 9);
      if (mode <= 3) begin
        hx = m_fx; hy = m_fy;
      end else if (mode == 4 && len > 1) begin
        k = $urandom_range(1, len - 1);
        hx = bx[k]; hy = by[k];
      end else if (mode == 5) begin
        hx = $urandom_range(60, 70); hy = $urandom_range(44, 52);
      end else begin
        hx = $urandom_range(0, DW - 1); hy = $urandom_range(0, DH - 1);
      end
      bx[0] = hx; by[0] = hy;
      tick();
    end

    // Drive the fruit into relocation, then reset in the middle of it
    for (int i = 0; i < N; i++) begin bx[i] = i; by[i] = 40; end
    len = 3; lives = 3;
    for (int n = 0; n < 20 && m_reloc == 1; n++) begin
      hx = 5; hy = 5; bx[0] = 5; by[0] = 5;
      tick();
    end
    hx = m_fx; hy = m_fy; bx[0] = hx; by[0] = hy;
    bx[1] = m_rand & 63;
    by[1] = ((m_rand >> 8) & 63) >= 48 ? ((m_rand >> 8) & 63) - 48 : ((m_rand >> 8) & 63);
    tick();
    hx = 5; hy = 5; bx[0] = 5; by[0] = 5;
    bx[1] = m_rand & 63;
    by[1] = ((m_rand >> 8) & 63) >= 48 ? ((m_rand >> 8) & 63) - 48 : ((m_rand >> 8) & 63);
    tick();
    #3;
    reset = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    check_reset("midrst_held");
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) begin bx[i] = i; by[i] = 40; end
    hx = 5; hy = 5; bx[0] = 5; by[0] = 5;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
